inv_key_schedule: RTL
=====================

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 Parameter: Nr, default 10, number of AES rounds; only 10 (AES-128, Nk=4) is supported; other values are illegal.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin a reverse schedule; sampled only in IDLE.
REQ-005 last_key  input  128  round-Nr key, words w[4Nr]..w[4Nr+3], first word in bits [127:96]; sampled on the accepted start.
REQ-006 rk_valid  output  1  rk/rk_round hold a valid round key.
REQ-007 rk_ready  input  1  downstream accepts rk this cycle.
REQ-008 rk  output  128  current round key, same word order as last_key.
REQ-009 rk_round  output  4  round index of rk: Nr down to 0.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after round-0 key is accepted.

Function
REQ-012 FSM states: IDLE, EMIT. IDLE -> EMIT on start; EMIT -> IDLE when the rk_round==0 key is accepted; no other transitions.
REQ-013 Accepted start at edge t: key register <= last_key, round <= Nr; rk_valid=1 from cycle t+1 with rk=last_key, rk_round=Nr.
REQ-014 Handshake: transfer occurs on any edge where rk_valid && rk_ready; rk, rk_round stable while rk_valid && !rk_ready.
REQ-015 On transfer with round r>0: next key presented the following cycle (one key per cycle at full throughput), round <= r-1.
REQ-016 Inverse step from round r key (w0,w1,w2,w3) to round r-1 key (p0..p3): p3=w3^w2; p2=w2^w1; p1=w1^w0; p0=w0 ^ SubWord(RotWord(p3)) ^ Rcon(r).
REQ-017 RotWord: left byte rotate {b[23:0],b[31:24]}; SubWord: forward AES S-box on each byte; Rcon(r) byte in [31:24] = 01,02,04,08,10,20,40,80,1b,36 for r=1..10, low 24 bits zero.
REQ-018 S-box implemented as four combinational lookup instances within this block; no RAM, no extra pipeline stage.
REQ-019 On transfer with round 0: rk_valid <= 0, done <= 1 for exactly one cycle, state <= IDLE.
REQ-020 start while busy is ignored, including start coincident with the final transfer; a new start is accepted only in a cycle where state is IDLE.
REQ-021 last_key changes after acceptance have no effect on the running sequence.
REQ-022 rk_ready while rk_valid=0 has no effect.

Reset
REQ-023 rst high at any edge, including mid-sequence: state <= IDLE, rk_valid=0, done=0, busy=0, rk_round=0, rk=0, key register cleared; any in-progress sequence is abandoned and not resumed.
REQ-024 rst has priority over start and over a transfer in the same cycle.

Configuration
REQ-025 Macro INV_KEY_ZEROIZE_EN: when defined, key register and rk are forced to 0 on the done cycle and rk reads 0 whenever rk_valid=0.
REQ-026 Without INV_KEY_ZEROIZE_EN: after done, rk and key register hold the round-0 key until the next accepted start or reset.

Verification
REQ-027 FIPS-197 A.1: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, start, rk_ready=1 -> 11 consecutive keys; round 9 = ac7766f319fadc2128d12941575c006e, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done pulses once, on the cycle after the round-0 transfer.
REQ-028 Backpressure: same stimulus, rk_ready toggled pseudo-randomly -> identical 11-key sequence, rk/rk_round stable during every stall cycle.
REQ-029 start pulsed at rounds 7 and 0 with a different last_key -> ignored; sequence unchanged; new start accepted only after return to IDLE.
REQ-030 rst asserted while rk_round=5 -> next cycle all outputs 0, state IDLE; fresh start then produces the full correct sequence from round 10.
REQ-031 All-zero last_key, run to completion -> round-0 key matches software model; with INV_KEY_ZEROIZE_EN, rk=0 from the done cycle onward, without it rk holds the round-0 key.

Source files
------------

// File: rtl/inv_key_schedule_if.sv
// Handshake bundle for the AES-128 reverse key schedule: start/last_key request side
// and the rk_valid/rk_ready round-key stream plus busy/done status.
interface inv_key_schedule_if;
  logic         start;
  logic [127:0] last_key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  modport master (
    output start, last_key, rk_ready,
    input  rk_valid, rk, rk_round, busy, done
  );

  modport slave (
    input  start, last_key, rk_ready,
    output rk_valid, rk, rk_round, busy, done
  );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 reverse key schedule: emits round keys Nr..0, first key one cycle after start, one per cycle;
// holds rk/rk_round while rk_ready is low. Option INV_KEY_ZEROIZE_EN clears key state on done.
module inv_key_schedule #(
  parameter int Nr = 10
) (
  input logic               clk,
  input logic               rst,
  inv_key_schedule_if.slave bus
);

  if (Nr != 10) begin : g_nr_check
    $error("inv_key_schedule supports only Nr = 10");
  end

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(Nr);

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TBL[{~a, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot, sub;
  logic         xfer;

  // Round r-1 key recovered from round r key.
  always_comb begin
    {w0, w1, w2, w3} = key_q;
    p3  = w3 ^ w2;
    p2  = w2 ^ w1;
    p1  = w1 ^ w0;
    rot = {p3[23:0], p3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    p0  = w0 ^ sub ^ {rcon(round_q), 24'h000000};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    xfer    = valid_q && bus.rk_ready;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = EMIT;
          key_d   = bus.last_key;
          round_d = LAST_ROUND;
          valid_d = 1'b1;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
`ifdef INV_KEY_ZEROIZE_EN
            key_d   = '0;
`endif
          end else begin
            key_d   = {p0, p1, p2, p3};
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.rk_valid = valid_q;
`ifdef INV_KEY_ZEROIZE_EN
  assign bus.rk       = valid_q ? key_q : '0;
`else
  assign bus.rk       = key_q;
`endif
  assign bus.rk_round = round_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;

endmodule
